// File: rtl/hwpf_stride_req_buf.sv
// Prefetch request FIFO with outstanding-response limiter in front of the HPDcache prefetch port.
// Optional counters enabled by defining HWPF_STRIDE_REQ_BUF_STATS_EN.

package hwpf_stride_req_buf_pkg;
  typedef struct packed {
    logic [39:0] addr;
    logic [2:0]  size;
    logic [7:0]  tid;
    logic        need_rsp;
  } hpdcache_req_t;

  typedef struct packed {
    logic [7:0] tid;
    logic       error;
  } hpdcache_rsp_t;
endpackage

module hwpf_stride_req_buf
  import hwpf_stride_req_buf_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  hpdcache_req_t req_i,
  output logic          rsp_valid_o,
  output hpdcache_rsp_t rsp_o,
  output logic          hpdcache_req_valid_o,
  input  logic          hpdcache_req_ready_i,
  output hpdcache_req_t hpdcache_req_o,
  input  logic          hpdcache_rsp_valid_i,
  input  hpdcache_rsp_t hpdcache_rsp_i,
  output logic          idle_o,
  output logic          err_o
`ifdef HWPF_STRIDE_REQ_BUF_STATS_EN
  ,
  output logic [31:0]   stat_issued_o,
  output logic [31:0]   stat_stall_o,
  output logic [31:0]   stat_flushed_o
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  hpdcache_req_t r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [OW-1:0] r_outstanding;
  logic          r_err;

  hpdcache_req_t w_head;
  logic          w_credit_ok;
  logic          w_not_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_inc;
  logic          w_dec;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_not_empty = (r_count != '0);
  // Requests that expect no response never consume a credit.
  assign w_credit_ok = (r_outstanding < OW'(MAX_OUTSTANDING)) || !w_head.need_rsp;

  assign req_ready_o          = (r_count != CW'(DEPTH)) && !flush_i;
  assign hpdcache_req_valid_o = w_not_empty && w_credit_ok && !flush_i;
  assign hpdcache_req_o       = w_head;

  assign w_push = req_valid_i && req_ready_o;
  assign w_pop  = hpdcache_req_valid_o && hpdcache_req_ready_i;
  assign w_inc  = w_pop && w_head.need_rsp;
  assign w_dec  = hpdcache_rsp_valid_i;

  assign rsp_valid_o = hpdcache_rsp_valid_i;
  assign rsp_o       = hpdcache_rsp_i;

  assign idle_o = !w_not_empty && (r_outstanding == '0);
  assign err_o  = r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= req_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      // Push is blocked during flush, so wr_ptr is already final.
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_inc && !w_dec) begin
        r_outstanding <= r_outstanding + OW'(1);
      end else if (!w_inc && w_dec) begin
        if (r_outstanding == '0) begin
          r_err <= 1'b1;
        end else begin
          r_outstanding <= r_outstanding - OW'(1);
        end
      end
    end
  end

`ifdef HWPF_STRIDE_REQ_BUF_STATS_EN
  logic [31:0] r_stat_issued;
  logic [31:0] r_stat_stall;
  logic [31:0] r_stat_flushed;
  logic [32:0] w_flushed_sum;

  assign w_flushed_sum = {1'b0, r_stat_flushed} + 33'(r_count);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stat_issued  <= '0;
      r_stat_stall   <= '0;
      r_stat_flushed <= '0;
    end else begin
      if (w_pop && (r_stat_issued != '1)) begin
        r_stat_issued <= r_stat_issued + 32'd1;
      end
      if (w_not_empty && !w_credit_ok && (r_stat_stall != '1)) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
      if (flush_i) begin
        r_stat_flushed <= w_flushed_sum[32] ? '1 : w_flushed_sum[31:0];
      end
    end
  end

  assign stat_issued_o  = r_stat_issued;
  assign stat_stall_o   = r_stat_stall;
  assign stat_flushed_o = r_stat_flushed;
`endif

endmodule

// File: tb/tb_hwpf_stride_req_buf.sv
// Randomized scoreboard bench for hwpf_stride_req_buf: a queue model of the FIFO plus an
// integer credit model; the monitor compares every cycle against them.

module tb_hwpf_stride_req_buf;
  import hwpf_stride_req_buf_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b1;
  logic          flush_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  hpdcache_req_t req_i = '0;
  logic          rsp_valid_o;
  hpdcache_rsp_t rsp_o;
  logic          hpd_req_valid;
  logic          hpd_req_ready = 1'b0;
  hpdcache_req_t hpd_req;
  logic          hpd_rsp_valid = 1'b0;
  hpdcache_rsp_t hpd_rsp = '0;
  logic          idle_o;
  logic          err_o;

  hwpf_stride_req_buf #(
    .DEPTH          (DEPTH),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .req_i               (req_i),
    .rsp_valid_o         (rsp_valid_o),
    .rsp_o               (rsp_o),
    .hpdcache_req_valid_o(hpd_req_valid),
    .hpdcache_req_ready_i(hpd_req_ready),
    .hpdcache_req_o      (hpd_req),
    .hpdcache_rsp_valid_i(hpd_rsp_valid),
    .hpdcache_rsp_i      (hpd_rsp),
    .idle_o              (idle_o),
    .err_o               (err_o)
  );

  always #5 clk = ~clk;

  hpdcache_req_t exp_q[$];
  int            model_out = 0;
  bit            model_err = 1'b0;
  int            checks = 0;
  int            failures = 0;
  int            issued = 0;
  bit            mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: runs 2 time units after each negedge, once inputs for the cycle are settled.
  always @(negedge clk) begin
    #2;
    if (mon_en && rst_ni) begin
      bit exp_ready, exp_valid, inc;
      exp_ready = (exp_q.size() < DEPTH) && !flush_i;
      exp_valid = 1'b0;
      if (exp_q.size() != 0 && !flush_i) begin
        exp_valid = (model_out < MAXO) || !exp_q[0].need_rsp;
      end
      chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
      chk("hpd_req_valid", 64'(hpd_req_valid), 64'(exp_valid));
      chk("idle", 64'(idle_o), 64'(exp_q.size() == 0 && model_out == 0));
      chk("err", 64'(err_o), 64'(model_err));
      chk("rsp_valid", 64'(rsp_valid_o), 64'(hpd_rsp_valid));
      chk("rsp_payload", 64'(rsp_o), 64'(hpd_rsp));
      inc = 1'b0;
      if (exp_valid) begin
        chk("hpd_req_payload", 64'(hpd_req), 64'(exp_q[0]));
        if (hpd_req_ready) begin
          inc = exp_q[0].need_rsp;
          void'(exp_q.pop_front());
          issued++;
        end
      end
      if (inc && !hpd_rsp_valid) begin
        model_out++;
      end else if (!inc && hpd_rsp_valid) begin
        if (model_out == 0) model_err = 1'b1;
        else model_out--;
      end
    end
  end

  // One random cycle; the accepted request enters the model queue after the monitor has run.
  task automatic drive_cycle(input bit spurious, input bit hold_ready, input int flush_odds);
    bit acc;
    @(negedge clk);
    req_valid_i = ($urandom_range(0, 3) != 0);
    req_i.addr = {8'($urandom), 32'($urandom)};
    req_i.size = 3'($urandom);
    req_i.tid = 8'($urandom);
    req_i.need_rsp = ($urandom_range(0, 3) != 0);
    flush_i = ($urandom_range(0, flush_odds - 1) == 0);
    hpd_req_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
    if (spurious) hpd_rsp_valid = ($urandom_range(0, 4) == 0);
    else hpd_rsp_valid = (model_out > 0) && ($urandom_range(0, 2) == 0);
    hpd_rsp = 9'($urandom);
    #1;
    acc = req_valid_i && !flush_i && (exp_q.size() < DEPTH);
    #2;
    if (flush_i) exp_q.delete();
    else if (acc) exp_q.push_back(req_i);
  endtask

  initial begin
    #1 rst_ni = 1'b0;
    #1;
    chk("reset_req_ready", 64'(req_ready_o), 64'd1);
    chk("reset_hpd_valid", 64'(hpd_req_valid), 64'd0);
    chk("reset_idle", 64'(idle_o), 64'd1);
    chk("reset_err", 64'(err_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    mon_en = 1'b1;

    // Fill with the cache stalled, then drain; repeated to exercise full/credit boundaries.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 12; i++) drive_cycle(1'b0, 1'b1, 1000);
      for (int i = 0; i < 30; i++) drive_cycle(1'b0, 1'b0, 1000);
    end
    for (int i = 0; i < 2000; i++) drive_cycle(1'b0, 1'b0, 25);

    // Build up state, then reset asynchronously mid-cycle.
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b0, 1000);
    @(negedge clk);
    #4;
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    hpd_rsp_valid = 1'b0;
    hpd_req_ready = 1'b0;
    rst_ni = 1'b0;
    exp_q.delete();
    model_out = 0;
    model_err = 1'b0;
    #1;
    chk("midreset_req_ready", 64'(req_ready_o), 64'd1);
    chk("midreset_hpd_valid", 64'(hpd_req_valid), 64'd0);
    chk("midreset_idle", 64'(idle_o), 64'd1);
    chk("midreset_err", 64'(err_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    // A response with nothing outstanding must set the sticky error.
    @(negedge clk);
    hpd_rsp_valid = 1'b1;
    hpd_rsp = 9'h1a5;
    @(negedge clk);
    hpd_rsp_valid = 1'b0;
    for (int i = 0; i < 1500; i++) drive_cycle(1'b1, 1'b0, 30);

    @(negedge clk);
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    hpd_rsp_valid = 1'b0;
    #4;
    checks++;
    if (issued < 100) begin
      failures++;
      $display("FAIL issue_progress: got %0d issued, expected at least 100", issued);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
